// File: rtl/dram_bram_responder.sv
// Block-RAM responder for the MemoryController user interface: clears memory after reset,
// then serves single-word reads and byte-masked writes with a fixed latency. Optional check: MEMRESP_ERRCHK_EN.
module dram_bram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        read_a,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mask,
  output logic [31:0] dout_a,
  output logic        busy,
  output logic        mem_initialized,
  output logic        fail
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [7:0]  LAT_LOAD  = 8'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] INIT_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   init_ctr_reg;
  logic [7:0]          lat_ctr_reg;
  logic                busy_reg;
  logic                mem_init_reg;
  logic                rd_pending_reg;
  logic [31:0]         dout_reg;
  logic [31:0]         rd_word_reg;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                rd_en;
  logic                wr_accept;
  logic [ADDR_W-1:0]   req_idx;
  logic [ADDR_W-1:0]   mem_idx;
  logic [31:0]         mem_wdata;
  logic [3:0]          lane_we;

  assign req_idx   = addr[ADDR_W+1:2];
  assign accept    = (state_reg == ST_IDLE) && !busy_reg && (read_a || write);
  assign rd_en     = accept && read_a;
  // Read wins over a simultaneous write, so the write port stays idle in that case.
  assign wr_accept = accept && write && !read_a;

  assign mem_idx   = (state_reg == ST_INIT) ? init_ctr_reg : req_idx;
  assign mem_wdata = (state_reg == ST_INIT) ? 32'h0 : din;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
      assign lane_we[gi] = (state_reg == ST_INIT) || (wr_accept && !mask[gi]);
    end
  endgenerate

  // Single-port RAM with registered, read-first output; never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_word_reg <= mem[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_reg      <= ST_INIT;
      init_ctr_reg   <= '0;
      lat_ctr_reg    <= '0;
      busy_reg       <= 1'b1;
      mem_init_reg   <= 1'b0;
      rd_pending_reg <= 1'b0;
      dout_reg       <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_ctr_reg <= init_ctr_reg + 1'b1;
          if (init_ctr_reg == INIT_LAST) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            mem_init_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (read_a || write) begin
            state_reg      <= ST_WAIT;
            busy_reg       <= 1'b1;
            lat_ctr_reg    <= LAT_LOAD;
            rd_pending_reg <= read_a;
          end
        end
        ST_WAIT: begin
          if (lat_ctr_reg == 8'd0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            if (rd_pending_reg) begin
              dout_reg <= rd_word_reg;
            end
          end else begin
            lat_ctr_reg <= lat_ctr_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_INIT;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign dout_a          = dout_reg;
  assign busy            = busy_reg;
  assign mem_initialized = mem_init_reg;

`ifdef MEMRESP_ERRCHK_EN
  logic fail_reg;
  logic addr_alias;
  logic [1:0] unused_addr;

  assign addr_alias  = (addr >> (ADDR_W + 2)) != 32'h0;
  assign unused_addr = addr[1:0];

  // Sticky: once a bad request is seen only reset clears it.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      fail_reg <= 1'b0;
    end else if (accept && ((read_a && write) || addr_alias)) begin
      fail_reg <= 1'b1;
    end
  end

  assign fail = fail_reg;
`else
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_dram_bram_responder.sv
// Directed bench for dram_bram_responder (ADDR_W=4, LATENCY=4): init sweep, latency, masks, aliasing, reset.
module tb_dram_bram_responder;

  localparam int ADDR_W  = 4;
  localparam int LATENCY = 4;
  localparam int SWEEP   = 2 ** ADDR_W;

`ifdef MEMRESP_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_x;
  logic        read_a;
  logic        write;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  mask;
  logic [31:0] dout_a;
  logic        busy;
  logic        mem_initialized;
  logic        fail;

  int vectors    = 0;
  int miscompares = 0;

  dram_bram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst_x(rst_x),
    .read_a(read_a),
    .write(write),
    .addr(addr),
    .din(din),
    .mask(mask),
    .dout_a(dout_a),
    .busy(busy),
    .mem_initialized(mem_initialized),
    .fail(fail)
  );

  always #5 clk = ~clk;

  // Drive one request from a negedge with busy=0; returns the number of busy-high cycles seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, output int bcnt);
    int w;
    w = 0;
    while (busy && w < 300) begin
      w++;
      @(negedge clk);
    end
    read_a = rd;
    write  = wr;
    addr   = a;
    din    = d;
    mask   = m;
    @(posedge clk);
    #1;
    read_a = 1'b0;
    write  = 1'b0;
    @(negedge clk);
    bcnt = 0;
    while (busy && bcnt < 300) begin
      bcnt++;
      @(negedge clk);
    end
    if (bcnt >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL access_timeout addr=%h: busy never fell", a);
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0; read_a = 1'b0; write = 1'b0;
    addr = 32'h0; din = 32'h0; mask = 4'hF;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got=%b exp=1", busy); end
    vectors++; if (dout_a !== 32'h0) begin miscompares++; $display("FAIL reset_dout got=%h exp=00000000", dout_a); end
    vectors++; if (mem_initialized !== 1'b0) begin miscompares++; $display("FAIL reset_meminit got=%b exp=0", mem_initialized); end
    vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail got=%b exp=0", fail); end
    $display("reset: busy=%b dout_a=%h mem_initialized=%b fail=%b", busy, dout_a, mem_initialized, fail);
  endtask

  task automatic test_init();
    int cnt;
    int bcnt;
    rst_x = 1'b1;
    // Request held high during the sweep must be ignored.
    write = 1'b1; addr = 32'h8; din = 32'hFFFF_FFFF; mask = 4'h0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    write = 1'b0;
    vectors++; if (cnt !== SWEEP) begin miscompares++; $display("FAIL init_busy_cycles got=%0d exp=%0d", cnt, SWEEP); end
    vectors++; if (mem_initialized !== 1'b1) begin miscompares++; $display("FAIL init_meminit got=%b exp=1", mem_initialized); end
    $display("init: busy cycles=%0d mem_initialized=%b", cnt, mem_initialized);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'h0) begin miscompares++; $display("FAIL init_read8 got=%h exp=00000000", dout_a); end
    $display("read  addr=00000008 dout_a=%h", dout_a);
  endtask

  task automatic test_write_read();
    int bcnt;
    access(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'h0, bcnt);
    vectors++; if (bcnt !== LATENCY) begin miscompares++; $display("FAIL write_latency got=%0d exp=%0d", bcnt, LATENCY); end
    $display("write addr=00000008 din=deadbeef mask=0 busy cycles=%0d", bcnt);
    access(1'b1, 1'b0, 32'hA, 32'h0, 4'hF, bcnt);
    vectors++; if (bcnt !== LATENCY) begin miscompares++; $display("FAIL read_latency got=%0d exp=%0d", bcnt, LATENCY); end
    vectors++; if (dout_a !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_a_data got=%h exp=deadbeef", dout_a); end
    $display("read  addr=0000000a dout_a=%h busy cycles=%0d", dout_a, bcnt);
    access(1'b0, 1'b1, 32'h3C, 32'h1234_5678, 4'h0, bcnt);
    vectors++; if (dout_a !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL dout_hold got=%h exp=deadbeef", dout_a); end
    $display("write addr=0000003c din=12345678 dout_a held=%h", dout_a);
  endtask

  task automatic test_byte_mask();
    int bcnt;
    access(1'b0, 1'b1, 32'h8, 32'h1122_3344, 4'b1010, bcnt);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hDE22_BE44) begin miscompares++; $display("FAIL mask_1010 got=%h exp=de22be44", dout_a); end
    $display("mask 1010 read addr=00000008 dout_a=%h", dout_a);
    access(1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, bcnt);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hDE22_BE44) begin miscompares++; $display("FAIL mask_F_noop got=%h exp=de22be44", dout_a); end
    $display("mask F   read addr=00000008 dout_a=%h", dout_a);
    access(1'b0, 1'b1, 32'h3C, 32'hAABB_CCDD, 4'b0101, bcnt);
    access(1'b1, 1'b0, 32'h3C, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hAA34_CC78) begin miscompares++; $display("FAIL mask_0101 got=%h exp=aa34cc78", dout_a); end
    $display("mask 0101 read addr=0000003c dout_a=%h", dout_a);
  endtask

  task automatic test_both_requests();
    int bcnt;
    access(1'b1, 1'b1, 32'h8, 32'h0000_0000, 4'h0, bcnt);
    vectors++; if (dout_a !== 32'hDE22_BE44) begin miscompares++; $display("FAIL both_read_data got=%h exp=de22be44", dout_a); end
    vectors++; if (fail !== ERRCHK) begin miscompares++; $display("FAIL both_fail got=%b exp=%b", fail, ERRCHK); end
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hDE22_BE44) begin miscompares++; $display("FAIL both_mem_unchanged got=%h exp=de22be44", dout_a); end
    vectors++; if (fail !== ERRCHK) begin miscompares++; $display("FAIL both_fail_sticky got=%b exp=%b", fail, ERRCHK); end
    $display("both  addr=00000008 dout_a=%h fail=%b", dout_a, fail);
  endtask

  task automatic test_alias();
    int bcnt;
    access(1'b0, 1'b1, 32'h0000_004C, 32'hCAFE_F00D, 4'h0, bcnt);
    access(1'b1, 1'b0, 32'hC, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL alias_read got=%h exp=cafef00d", dout_a); end
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'hDE22_BE44) begin miscompares++; $display("FAIL alias_high_read got=%h exp=de22be44", dout_a); end
    $display("alias read addr=80000008 dout_a=%h", dout_a);
  endtask

  task automatic test_back_to_back();
    int cnt;
    read_a = 1'b1; addr = 32'hC;
    @(posedge clk);
    #1;
    @(negedge clk);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    vectors++; if (cnt !== LATENCY) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=%0d", cnt, LATENCY); end
    vectors++; if (dout_a !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_first_data got=%h exp=cafef00d", dout_a); end
    // read_a is still high here, so the next edge must start a second access.
    @(posedge clk);
    #1;
    read_a = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept busy=%b exp=1", busy); end
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    vectors++; if (cnt !== LATENCY) begin miscompares++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cnt, LATENCY); end
    $display("back-to-back read addr=0000000c dout_a=%h", dout_a);
  endtask

  task automatic test_reset_mid_wait();
    int cnt;
    int bcnt;
    read_a = 1'b1; addr = 32'h8;
    @(posedge clk);
    #1;
    read_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_x = 1'b0;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    vectors++; if (dout_a !== 32'h0) begin miscompares++; $display("FAIL midrst_dout got=%h exp=00000000", dout_a); end
    vectors++; if (mem_initialized !== 1'b0) begin miscompares++; $display("FAIL midrst_meminit got=%b exp=0", mem_initialized); end
    vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL midrst_fail got=%b exp=0", fail); end
    @(negedge clk);
    rst_x = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    vectors++; if (cnt !== SWEEP) begin miscompares++; $display("FAIL resweep_cycles got=%0d exp=%0d", cnt, SWEEP); end
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'h0) begin miscompares++; $display("FAIL resweep_word8 got=%h exp=00000000", dout_a); end
    access(1'b1, 1'b0, 32'h3C, 32'h0, 4'hF, bcnt);
    vectors++; if (dout_a !== 32'h0) begin miscompares++; $display("FAIL resweep_word15 got=%h exp=00000000", dout_a); end
    $display("reset mid-wait: re-sweep=%0d cycles, word 15 dout_a=%h", cnt, dout_a);
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_both_requests();
    test_alias();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
